// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
// Module   : cam_capture
// Purpose  : Parallel CMOS sensor capture. Registers the sensor bus once,
//            waits for sensor configuration, discards a number of warm-up
//            frames, then assembles PIX_BYTES bus beats into one pixel and
//            emits it with column/row, start-of-frame and end-of-line flags.
//            Malformed lines and frames are flagged with one-cycle pulses.
// Ports    : cmos_pclk   - sole clock (rising edge)
//            rst         - synchronous active-high reset
//            cmos_data   - sensor byte bus
//            cmos_href   - line valid
//            cmos_vsyn   - frame sync (high during vertical blanking)
//            cfg_done    - sensor configuration complete (asynchronous level)
//            capture_en  - frame gate, sampled at frame start only
//            pix_data    - assembled pixel, held between strobes
//            pix_valid   - one-cycle strobe for pix_data/pix_x/pix_y
//            pix_sof     - strobe qualifier for pixel (0,0)
//            pix_eol     - strobe qualifier for the last pixel of a line
//            pix_x/pix_y - column/row of the strobed pixel
//            frame_cnt   - completed well-formed captured frames (wraps)
//            err_line    - pulse on a malformed line
//            err_frame   - pulse on a malformed frame
//            busy        - high while a frame is being captured
// Revision : 1.0 - initial release
// ============================================================================
module cam_capture #(
    parameter int DATA_W      = 8,
    parameter int PIX_BYTES   = 2,
    parameter int MSB_FIRST   = 1,
    parameter int SKIP_FRAMES = 30,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic                          cmos_pclk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             cmos_data,
    input  logic                          cmos_href,
    input  logic                          cmos_vsyn,
    input  logic                          cfg_done,
    input  logic                          capture_en,
    output logic [DATA_W*PIX_BYTES-1:0]   pix_data,
    output logic                          pix_valid,
    output logic                          pix_sof,
    output logic                          pix_eol,
    output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]   pix_y,
    output logic [15:0]                   frame_cnt,
    output logic                          err_line,
    output logic                          err_frame,
    output logic                          busy
);

    localparam int c_PW = DATA_W * PIX_BYTES;
    localparam int c_XW = $clog2(H_ACTIVE);
    localparam int c_YW = $clog2(V_ACTIVE);
    localparam int c_BW = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    // Internal column/row counters saturate one above the active size so an
    // over-long line or frame is still distinguishable from a correct one.
    localparam int c_CW = $clog2(H_ACTIVE + 2);
    localparam int c_RW = $clog2(V_ACTIVE + 2);

    localparam logic [1:0] c_ST_WAIT_CFG = 2'd0;
    localparam logic [1:0] c_ST_SKIP     = 2'd1;
    localparam logic [1:0] c_ST_IDLE     = 2'd2;
    localparam logic [1:0] c_ST_ACTIVE   = 2'd3;

    // Stage-1 input registers, edge-detect history and cfg synchroniser.
    logic [DATA_W-1:0] r_data_s1;
    logic              r_href_s1;
    logic              r_vsyn_s1;
    logic              r_href_d;
    logic              r_vsyn_d;
    logic              r_cfg_meta;
    logic              r_cfg_sync;

    logic [1:0]        r_state;
    logic [7:0]        r_skip_cnt;
    logic [c_BW-1:0]   r_beat;
    logic [c_CW-1:0]   r_col;
    logic [c_RW-1:0]   r_row;
    logic [c_PW-1:0]   r_accum;

    logic [c_BW-1:0]   w_slot;
    logic [c_PW-1:0]   w_merged;
    logic              w_href_fall;
    logic              w_vsyn_rise;
    logic              w_vsyn_fall;
    logic              w_capture;
    logic              w_last_beat;
    logic              w_emit;
    logic              w_line_bad;
    logic [c_RW-1:0]   w_row_inc;
    logic [c_RW-1:0]   w_rows_final;
    logic              w_skip_done;

    assign w_href_fall  = r_href_d & ~r_href_s1;
    assign w_vsyn_rise  = r_vsyn_s1 & ~r_vsyn_d;
    assign w_vsyn_fall  = ~r_vsyn_s1 & r_vsyn_d;

    assign w_capture    = (r_state == c_ST_ACTIVE) && r_href_s1 && !r_vsyn_s1;
    assign w_last_beat  = (r_beat == c_BW'(PIX_BYTES - 1));
    assign w_emit       = w_capture && w_last_beat &&
                          (r_col < c_CW'(H_ACTIVE)) && (r_row < c_RW'(V_ACTIVE));
    assign w_line_bad   = (r_beat != '0) || (r_col != c_CW'(H_ACTIVE));
    assign w_row_inc    = (r_row == c_RW'(V_ACTIVE + 1)) ? r_row : r_row + 1'b1;
    // A line ending on the same cycle as the frame-closing vsync edge still
    // counts toward the frame's line total.
    assign w_rows_final = w_href_fall ? w_row_inc : r_row;
    assign w_skip_done  = (r_skip_cnt == 8'(SKIP_FRAMES));

    assign w_slot = (MSB_FIRST != 0) ? (c_BW'(PIX_BYTES - 1) - r_beat) : r_beat;

    // Current beat replaces its slot; the other slots keep earlier beats.
    genvar g;
    generate
        for (g = 0; g < PIX_BYTES; g++) begin : g_slot
            assign w_merged[g*DATA_W +: DATA_W] =
                (w_slot == c_BW'(g)) ? r_data_s1 : r_accum[g*DATA_W +: DATA_W];
        end
    endgenerate

    assign busy = (r_state == c_ST_ACTIVE);

    always_ff @(posedge cmos_pclk) begin
        if (rst) begin
            r_data_s1  <= '0;
            r_href_s1  <= 1'b0;
            r_vsyn_s1  <= 1'b0;
            r_href_d   <= 1'b0;
            r_vsyn_d   <= 1'b0;
            r_cfg_meta <= 1'b0;
            r_cfg_sync <= 1'b0;
            r_state    <= c_ST_WAIT_CFG;
            r_skip_cnt <= '0;
            r_beat     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_accum    <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            frame_cnt  <= '0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            r_data_s1  <= cmos_data;
            r_href_s1  <= cmos_href;
            r_vsyn_s1  <= cmos_vsyn;
            r_href_d   <= r_href_s1;
            r_vsyn_d   <= r_vsyn_s1;
            r_cfg_meta <= cfg_done;
            r_cfg_sync <= r_cfg_meta;

            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;

            if (!r_cfg_sync) begin
                // Sensor lost its configuration: restart the whole sequence.
                r_state    <= c_ST_WAIT_CFG;
                r_skip_cnt <= '0;
                r_beat     <= '0;
                r_col      <= '0;
            end else begin
                case (r_state)
                    c_ST_WAIT_CFG: begin
                        r_state <= c_ST_SKIP;
                    end
                    c_ST_SKIP: begin
                        if (w_skip_done) begin
                            r_state <= c_ST_IDLE;
                        end else if (w_vsyn_rise) begin
                            r_skip_cnt <= r_skip_cnt + 1'b1;
                        end
                    end
                    c_ST_IDLE: begin
                        if (w_vsyn_fall && capture_en) begin
                            r_state <= c_ST_ACTIVE;
                            r_beat  <= '0;
                            r_col   <= '0;
                            r_row   <= '0;
                            pix_y   <= '0;
                        end
                    end
                    c_ST_ACTIVE: begin
                        if (w_capture) begin
                            if (w_last_beat) begin
                                r_beat <= '0;
                                if (r_col != c_CW'(H_ACTIVE + 1)) begin
                                    r_col <= r_col + 1'b1;
                                end
                                if (w_emit) begin
                                    pix_data  <= w_merged;
                                    pix_valid <= 1'b1;
                                    pix_x     <= r_col[c_XW-1:0];
                                    pix_y     <= r_row[c_YW-1:0];
                                    pix_sof   <= (r_col == '0) && (r_row == '0);
                                    pix_eol   <= (r_col == c_CW'(H_ACTIVE - 1));
                                end
                            end else begin
                                r_accum <= w_merged;
                                r_beat  <= r_beat + 1'b1;
                            end
                        end
                        if (w_href_fall) begin
                            err_line <= w_line_bad;
                            r_row    <= w_row_inc;
                        end
                        if (w_vsyn_rise) begin
                            r_state <= c_ST_IDLE;
                            if (w_rows_final != c_RW'(V_ACTIVE)) begin
                                err_frame <= 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + 16'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_ST_WAIT_CFG;
                    end
                endcase

                // Every line end drops a partial pixel and restarts the column.
                if (w_href_fall) begin
                    r_beat <= '0;
                    r_col  <= '0;
                    pix_x  <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
